riscv_bus_ram: RTL and testbench
================================

# riscv_bus_ram

Single-clock word-addressed RAM acting as the slave (responder) end of `dualport_bus`, serving the core's instruction fetch port or data port. It answers the independent read and write channels, grants each request after a programmable number of wait cycles, and returns read data one cycle after the grant. Programmable wait states exercise the masters' `rd_req & ~rd_gnt` busy/stall paths.

## Interface
- `DEPTH_WORDS`, 4096: RAM size in 32-bit words, power of two.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0, word aligned.
- `RD_WAIT`, 0: wait cycles before each read grant, 0..15.
- `WR_WAIT`, 0: wait cycles before each write grant, 0..15.
- `INIT_FILE`, "": hex image loaded at elaboration via `$readmemh`; none if empty.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `bus_slave`  `dualport_bus.slave`  –  rd_req/rd_be/rd_addr in, rd_gnt/rd_data out; wr_req/wr_be/wr_addr/wr_data in, wr_gnt out.
- `o_rd_err`  out  1  one-cycle pulse: granted read was out of range.
- `o_wr_err`  out  1  one-cycle pulse: granted write was out of range.

## Operation
- Index = `(addr - BASE_ADDR) >> 2`, width `ADDR_W = $clog2(DEPTH_WORDS)`. `addr[1:0]` is ignored.
- In range means `addr >= BASE_ADDR` and `(addr - BASE_ADDR) >> 2 < DEPTH_WORDS`, computed at 32 bits with no wrap.
- Each channel has its own wait counter `cnt`, 4 bits:
  - Idle value is the channel's `*_WAIT`.
  - `req & cnt != 0`: decrement.
  - `gnt = req & (cnt == 0) & ~rst`, combinational.
  - On `gnt`, or when `req` drops before grant, reload `*_WAIT`.
- `*_WAIT = 0`: every requested cycle is granted, one transfer per cycle.
- `*_WAIT = N`: each transfer takes N+1 cycles, N cycles of `req & ~gnt` followed by the granting cycle.
- Address or byte enables changing during wait cycles do not restart the counter. The values sampled in the grant cycle are used.
- Read:
  - In the cycle after grant, `rd_data` = word at the grant-cycle address, with bytes where `rd_be[i]=0` forced to 0.
  - Out-of-range read returns 32'h0 and pulses `o_rd_err` in the cycle after grant.
  - `rd_data` holds its value until the next read grant.
- Write:
  - At the grant-cycle edge, bytes with `wr_be[i]=1` are written.
  - `wr_be = 0` is a granted no-op.
  - Out-of-range write: nothing is stored and `o_wr_err` pulses in the cycle after grant.
- Simultaneous read and write grant to the same word is read-before-write: `rd_data` returns the old word, and the new word is visible to the next read.
- Reset:
  - `rd_data` = 0, `o_rd_err` = `o_wr_err` = 0, both counters reload.
  - `gnt` is forced low during `rst`.
  - RAM contents are not cleared.
  - Reset during a wait aborts the transaction. Counting restarts from `*_WAIT` after `rst` falls.

## Timing
- Cycle 0: `req` asserted. Cycle N: `gnt`, with N = `*_WAIT`. Cycle N+1: read data and error pulses valid.
- Write data is committed at the end of cycle N.
- No combinational path from `wr_*` to `rd_data`. `rd_data` and the error outputs are registered.
- `gnt` depends combinationally only on `req`, `rst` and the counter.

## Structure
- `riscv_bus_pkg` holds:
  - `BUS_DW = 32` and `BUS_AW = 32`.
  - A byte-mask function expanding `be[3:0]` to a 32-bit mask.
  - A `wait_cnt_t` typedef, 4 bits.
- Sub-module `riscv_bus_wait_ctr`:
  - Parameter `WAIT`; ports `clk`, `rst`, `req`, `gnt`.
  - Instantiated once per channel.
- RAM array is inferred in the top: one synchronous read port and one byte-enabled write port.

## Test plan
- `RD_WAIT=0`: back-to-back reads of 0x00, 0x04, 0x08 from an image holding 0x11111111, 0x22222222, 0x33333333.
  - Required: `rd_gnt` high every cycle and data returned in order, one cycle after each grant.
- `RD_WAIT=2`: hold `rd_req`.
  - Required: `rd_gnt` pattern 0,0,1 repeating, data after each grant.
  - Dropping `rd_req` in the second wait cycle and reasserting it must take 3 more cycles to grant.
- Write 0xDEADBEEF with `wr_be=4'b0101` to a word holding 0, then read it with `rd_be=4'hf`.
  - Required: read returns 0x00AD00EF.
- Same-cycle read and write grant to address 0x10 (old value 0xA5A5A5A5, new value 0x5A5A5A5A).
  - Required: read returns 0xA5A5A5A5; the next read returns 0x5A5A5A5A.
- Out-of-range accesses with `BASE_ADDR=0x1000`, `DEPTH_WORDS=16`:
  - Read at 0x0FFC: returns 0 with an `o_rd_err` pulse.
  - Write at 0x1040: `o_wr_err` pulse and no RAM change.
- Assert `rst` mid-wait with `RD_WAIT=3`.
  - Required: `rd_gnt` low during `rst` and `rd_data` = 0.
  - After release, the grant comes 3 cycles after `rd_req` is next seen.

Source files
------------

// File: rtl/riscv_bus_pkg.sv
// Shared widths, wait-counter type and byte-mask helper for the dual-port
// instruction/data bus and the RAM that responds on it.
package riscv_bus_pkg;

  localparam int BUS_DW = 32;
  localparam int BUS_AW = 32;
  localparam int BUS_BW = BUS_DW / 8;

  typedef logic [3:0] wait_cnt_t;

  // Expands one enable bit per byte lane into a full-width data mask.
  function automatic logic [BUS_DW-1:0] be_to_mask(input logic [BUS_BW-1:0] be);
    logic [BUS_DW-1:0] mask;
    mask = '0;
    for (int i = 0; i < BUS_BW; i++) begin
      mask[i*8 +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/riscv_bus_ram_if.sv
// Dual-channel core bus: an independent read channel and write channel,
// each with its own request/grant handshake.
interface dualport_bus;
  import riscv_bus_pkg::*;

  logic              rd_req;
  logic [BUS_BW-1:0] rd_be;
  logic [BUS_AW-1:0] rd_addr;
  logic              rd_gnt;
  logic [BUS_DW-1:0] rd_data;

  logic              wr_req;
  logic [BUS_BW-1:0] wr_be;
  logic [BUS_AW-1:0] wr_addr;
  logic [BUS_DW-1:0] wr_data;
  logic              wr_gnt;

  modport master (
    output rd_req, rd_be, rd_addr,
    input  rd_gnt, rd_data,
    output wr_req, wr_be, wr_addr, wr_data,
    input  wr_gnt
  );

  modport slave (
    input  rd_req, rd_be, rd_addr,
    output rd_gnt, rd_data,
    input  wr_req, wr_be, wr_addr, wr_data,
    output wr_gnt
  );

endinterface

// File: rtl/riscv_bus_wait_ctr.sv
// Per-channel wait-state generator: holds off the grant for WAIT cycles of
// continuous request, then grants for one cycle and rearms.
module riscv_bus_wait_ctr
  import riscv_bus_pkg::*;
#(
  parameter int WAIT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic gnt
);

  localparam wait_cnt_t RELOAD = wait_cnt_t'(WAIT);

  wait_cnt_t cnt;

  assign gnt = req & (cnt == '0) & ~rst;

  // A dropped request abandons the partial wait, so the next one starts over.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= RELOAD;
    end else if (!req || gnt) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/riscv_bus_ram.sv
// Word-addressed RAM responding on the dual-port core bus with programmable
// read/write wait states, byte enables and out-of-range error pulses.
module riscv_bus_ram
  import riscv_bus_pkg::*;
#(
  parameter int                DEPTH_WORDS = 4096,
  parameter logic [BUS_AW-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                RD_WAIT     = 0,
  parameter int                WR_WAIT     = 0,
  parameter string             INIT_FILE   = ""
) (
  input  logic         clk,
  input  logic         rst,
  dualport_bus.slave   bus_slave,
  output logic         o_rd_err,
  output logic         o_wr_err
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);

  logic [BUS_DW-1:0] mem [DEPTH_WORDS];

  logic              rd_gnt;
  logic              wr_gnt;
  logic [BUS_AW-1:0] rd_off;
  logic [BUS_AW-1:0] wr_off;
  logic              rd_ok;
  logic              wr_ok;
  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] wr_idx;

  riscv_bus_wait_ctr #(.WAIT(RD_WAIT)) u_rd_wait (
    .clk (clk),
    .rst (rst),
    .req (bus_slave.rd_req),
    .gnt (rd_gnt)
  );

  riscv_bus_wait_ctr #(.WAIT(WR_WAIT)) u_wr_wait (
    .clk (clk),
    .rst (rst),
    .req (bus_slave.wr_req),
    .gnt (wr_gnt)
  );

  assign bus_slave.rd_gnt = rd_gnt;
  assign bus_slave.wr_gnt = wr_gnt;

  // The lower-bound test stops addresses below the base from wrapping into range.
  assign rd_off = bus_slave.rd_addr - BASE_ADDR;
  assign wr_off = bus_slave.wr_addr - BASE_ADDR;
  assign rd_ok  = (bus_slave.rd_addr >= BASE_ADDR) && ((rd_off >> 2) < BUS_AW'(DEPTH_WORDS));
  assign wr_ok  = (bus_slave.wr_addr >= BASE_ADDR) && ((wr_off >> 2) < BUS_AW'(DEPTH_WORDS));
  assign rd_idx = rd_off[ADDR_W+1:2];
  assign wr_idx = wr_off[ADDR_W+1:2];

  always_ff @(posedge clk) begin
    if (wr_gnt && wr_ok) begin
      for (int i = 0; i < BUS_BW; i++) begin
        if (bus_slave.wr_be[i]) begin
          mem[wr_idx][i*8 +: 8] <= bus_slave.wr_data[i*8 +: 8];
        end
      end
    end
  end

  // Reads sample the pre-write word, giving read-before-write on collisions.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_slave.rd_data <= '0;
    end else if (rd_gnt) begin
      bus_slave.rd_data <= rd_ok ? (mem[rd_idx] & be_to_mask(bus_slave.rd_be)) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_rd_err <= 1'b0;
      o_wr_err <= 1'b0;
    end else begin
      o_rd_err <= rd_gnt & ~rd_ok;
      o_wr_err <= wr_gnt & ~wr_ok;
    end
  end

endmodule

// File: tb/tb_riscv_bus_ram.sv
// Directed bench for riscv_bus_ram: four instances cover zero-wait, two-wait,
// three-wait/reset and small offset-window configurations.
module tb_riscv_bus_ram;
  import riscv_bus_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic rd_err0, wr_err0, rd_err2, wr_err2, rd_err3, wr_err3, rd_erro, wr_erro;

  always #5 clk = ~clk;

  dualport_bus b0();
  dualport_bus b2();
  dualport_bus b3();
  dualport_bus bo();

  riscv_bus_ram #(.DEPTH_WORDS(4096), .BASE_ADDR(32'h0), .RD_WAIT(0), .WR_WAIT(0), .INIT_FILE("")) dut0 (
    .clk(clk), .rst(rst), .bus_slave(b0), .o_rd_err(rd_err0), .o_wr_err(wr_err0));

  riscv_bus_ram #(.DEPTH_WORDS(4096), .BASE_ADDR(32'h0), .RD_WAIT(2), .WR_WAIT(0), .INIT_FILE("")) dut2 (
    .clk(clk), .rst(rst), .bus_slave(b2), .o_rd_err(rd_err2), .o_wr_err(wr_err2));

  riscv_bus_ram #(.DEPTH_WORDS(4096), .BASE_ADDR(32'h0), .RD_WAIT(3), .WR_WAIT(0), .INIT_FILE("")) dut3 (
    .clk(clk), .rst(rst), .bus_slave(b3), .o_rd_err(rd_err3), .o_wr_err(wr_err3));

  riscv_bus_ram #(.DEPTH_WORDS(16), .BASE_ADDR(32'h1000), .RD_WAIT(0), .WR_WAIT(0), .INIT_FILE("")) duto (
    .clk(clk), .rst(rst), .bus_slave(bo), .o_rd_err(rd_erro), .o_wr_err(wr_erro));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sel: 0 = b0, 1 = b2, 2 = b3, 3 = bo (all have zero write wait)
  task automatic bus_write(input int sel, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    case (sel)
      0: begin b0.wr_req = 1; b0.wr_addr = a; b0.wr_data = d; b0.wr_be = be; end
      1: begin b2.wr_req = 1; b2.wr_addr = a; b2.wr_data = d; b2.wr_be = be; end
      2: begin b3.wr_req = 1; b3.wr_addr = a; b3.wr_data = d; b3.wr_be = be; end
      default: begin bo.wr_req = 1; bo.wr_addr = a; bo.wr_data = d; bo.wr_be = be; end
    endcase
    tick();
    b0.wr_req = 0; b2.wr_req = 0; b3.wr_req = 0; bo.wr_req = 0;
  endtask

  // Single-cycle read on a zero-wait instance (b0 or bo).
  task automatic bus_read(input int sel, input logic [31:0] a, input logic [3:0] be);
    if (sel == 0) begin b0.rd_req = 1; b0.rd_addr = a; b0.rd_be = be; end
    else          begin bo.rd_req = 1; bo.rd_addr = a; bo.rd_be = be; end
    tick();
    b0.rd_req = 0; bo.rd_req = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    b0.rd_req = 1; b0.rd_addr = 32'h0; b0.rd_be = 4'hf;
    b0.wr_req = 1; b0.wr_addr = 32'h0; b0.wr_data = 32'h0; b0.wr_be = 4'hf;
    tick(); tick();
    checks++; if (b0.rd_gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_gnt: got %b, expected 0", b0.rd_gnt); end
    checks++; if (b0.wr_gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_gnt: got %b, expected 0", b0.wr_gnt); end
    checks++; if (b0.rd_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_rd_data: got %h, expected 00000000", b0.rd_data); end
    checks++; if ({rd_err0, wr_err0, rd_erro, wr_erro} !== 4'b0) begin errors++; $display("[TB] FAIL reset_err: got %b, expected 0000", {rd_err0, wr_err0, rd_erro, wr_erro}); end
    b0.rd_req = 0; b0.wr_req = 0;
    rst = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3] = '{32'h0, 32'h4, 32'h8};
    logic [31:0] exp   [3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    for (int i = 0; i < 3; i++) bus_write(0, addrs[i], exp[i], 4'hf);
    b0.rd_req = 1; b0.rd_be = 4'hf;
    for (int i = 0; i < 3; i++) begin
      b0.rd_addr = addrs[i];
      #1;
      checks++; if (b0.rd_gnt !== 1'b1) begin errors++; $display("[TB] FAIL b2b_gnt%0d: got %b, expected 1", i, b0.rd_gnt); end
      tick();
      checks++; if (b0.rd_data !== exp[i]) begin errors++; $display("[TB] FAIL b2b_data%0d: got %h, expected %h", i, b0.rd_data, exp[i]); end
    end
    b0.rd_req = 0;
    tick();
  endtask

  task automatic test_byte_enable();
    bus_write(0, 32'h20, 32'h0, 4'hf);
    bus_write(0, 32'h20, 32'hDEAD_BEEF, 4'b0101);
    bus_read(0, 32'h20, 4'hf);
    checks++; if (b0.rd_data !== 32'h00AD_00EF) begin errors++; $display("[TB] FAIL be_write: got %h, expected 00ad00ef", b0.rd_data); end
    bus_write(0, 32'h20, 32'hFFFF_FFFF, 4'b0000);
    bus_read(0, 32'h20, 4'hf);
    checks++; if (b0.rd_data !== 32'h00AD_00EF) begin errors++; $display("[TB] FAIL be_zero_noop: got %h, expected 00ad00ef", b0.rd_data); end
    bus_read(0, 32'h0, 4'b1001);
    checks++; if (b0.rd_data !== 32'h1100_0011) begin errors++; $display("[TB] FAIL be_read_mask: got %h, expected 11000011", b0.rd_data); end
  endtask

  task automatic test_same_cycle();
    bus_write(0, 32'h10, 32'hA5A5_A5A5, 4'hf);
    b0.rd_req = 1; b0.rd_addr = 32'h10; b0.rd_be = 4'hf;
    b0.wr_req = 1; b0.wr_addr = 32'h10; b0.wr_data = 32'h5A5A_5A5A; b0.wr_be = 4'hf;
    #1;
    checks++; if ({b0.rd_gnt, b0.wr_gnt} !== 2'b11) begin errors++; $display("[TB] FAIL rw_gnt: got %b, expected 11", {b0.rd_gnt, b0.wr_gnt}); end
    tick();
    b0.wr_req = 0;
    checks++; if (b0.rd_data !== 32'hA5A5_A5A5) begin errors++; $display("[TB] FAIL rw_old: got %h, expected a5a5a5a5", b0.rd_data); end
    tick();
    b0.rd_req = 0;
    checks++; if (b0.rd_data !== 32'h5A5A_5A5A) begin errors++; $display("[TB] FAIL rw_new: got %h, expected 5a5a5a5a", b0.rd_data); end
  endtask

  task automatic test_wait_states();
    logic exp_gnt;
    bus_write(1, 32'h0, 32'hCAFE_0001, 4'hf);
    bus_write(1, 32'h4, 32'hCAFE_0002, 4'hf);
    b2.rd_req = 1; b2.rd_be = 4'hf;
    for (int c = 0; c < 6; c++) begin
      b2.rd_addr = (c < 3) ? 32'h0 : ((c < 5) ? 32'h8 : 32'h4);
      exp_gnt = (c % 3 == 2);
      #1;
      checks++; if (b2.rd_gnt !== exp_gnt) begin errors++; $display("[TB] FAIL wait_gnt%0d: got %b, expected %b", c, b2.rd_gnt, exp_gnt); end
      tick();
      if (c == 2 || c == 4) begin
        checks++; if (b2.rd_data !== 32'hCAFE_0001) begin errors++; $display("[TB] FAIL wait_data%0d: got %h, expected cafe0001", c, b2.rd_data); end
      end
      if (c == 5) begin
        checks++; if (b2.rd_data !== 32'hCAFE_0002) begin errors++; $display("[TB] FAIL wait_data5: got %h, expected cafe0002", b2.rd_data); end
      end
    end
    b2.rd_req = 0;
    tick();
    // Request, then drop it in the second wait cycle, then reassert.
    b2.rd_addr = 32'h0; b2.rd_req = 1;
    #1;
    checks++; if (b2.rd_gnt !== 1'b0) begin errors++; $display("[TB] FAIL drop_first: got %b, expected 0", b2.rd_gnt); end
    tick();
    b2.rd_req = 0;
    tick();
    b2.rd_req = 1;
    for (int k = 0; k < 3; k++) begin
      exp_gnt = (k == 2);
      #1;
      checks++; if (b2.rd_gnt !== exp_gnt) begin errors++; $display("[TB] FAIL drop_regnt%0d: got %b, expected %b", k, b2.rd_gnt, exp_gnt); end
      tick();
    end
    b2.rd_req = 0;
    checks++; if (b2.rd_data !== 32'hCAFE_0001) begin errors++; $display("[TB] FAIL drop_data: got %h, expected cafe0001", b2.rd_data); end
  endtask

  task automatic test_out_of_range();
    bus_write(3, 32'h1000, 32'h1234_5678, 4'hf);
    bus_write(3, 32'h103C, 32'h7777_7777, 4'hf);
    checks++; if (wr_erro !== 1'b0) begin errors++; $display("[TB] FAIL oor_wr_inrange: got %b, expected 0", wr_erro); end
    bus_read(3, 32'h103C, 4'hf);
    checks++; if ({rd_erro, bo.rd_data} !== {1'b0, 32'h7777_7777}) begin errors++; $display("[TB] FAIL oor_rd_last: got %h, expected 077777777", {rd_erro, bo.rd_data}); end
    bus_read(3, 32'h0FFC, 4'hf);
    checks++; if ({rd_erro, bo.rd_data} !== {1'b1, 32'h0}) begin errors++; $display("[TB] FAIL oor_rd_below: got %h, expected 100000000", {rd_erro, bo.rd_data}); end
    tick();
    checks++; if (rd_erro !== 1'b0) begin errors++; $display("[TB] FAIL oor_rd_pulse: got %b, expected 0", rd_erro); end
    bus_write(3, 32'h1040, 32'hFFFF_FFFF, 4'hf);
    checks++; if (wr_erro !== 1'b1) begin errors++; $display("[TB] FAIL oor_wr_above: got %b, expected 1", wr_erro); end
    tick();
    checks++; if (wr_erro !== 1'b0) begin errors++; $display("[TB] FAIL oor_wr_pulse: got %b, expected 0", wr_erro); end
    bus_write(3, 32'h0FFC, 32'hEEEE_EEEE, 4'hf);
    checks++; if (wr_erro !== 1'b1) begin errors++; $display("[TB] FAIL oor_wr_below: got %b, expected 1", wr_erro); end
    bus_read(3, 32'h1000, 4'hf);
    checks++; if (bo.rd_data !== 32'h1234_5678) begin errors++; $display("[TB] FAIL oor_keep_first: got %h, expected 12345678", bo.rd_data); end
    bus_read(3, 32'h103C, 4'hf);
    checks++; if (bo.rd_data !== 32'h7777_7777) begin errors++; $display("[TB] FAIL oor_keep_last: got %h, expected 77777777", bo.rd_data); end
  endtask

  task automatic test_reset_mid_wait();
    logic exp_gnt;
    bus_write(2, 32'h0, 32'hBEEF_0003, 4'hf);
    b3.rd_req = 1; b3.rd_addr = 32'h0; b3.rd_be = 4'hf;
    for (int k = 0; k < 4; k++) tick();
    b3.rd_req = 0;
    checks++; if (b3.rd_data !== 32'hBEEF_0003) begin errors++; $display("[TB] FAIL rstw_pre: got %h, expected beef0003", b3.rd_data); end
    tick();
    b3.rd_req = 1;
    tick(); tick(); tick();
    // Counter has reached zero here; reset must still suppress the grant.
    rst = 1;
    b0.rd_req = 1; b0.rd_addr = 32'h0; b0.rd_be = 4'hf;
    #1;
    checks++; if ({b3.rd_gnt, b0.rd_gnt} !== 2'b00) begin errors++; $display("[TB] FAIL rstw_gnt: got %b, expected 00", {b3.rd_gnt, b0.rd_gnt}); end
    tick();
    checks++; if (b3.rd_data !== 32'h0) begin errors++; $display("[TB] FAIL rstw_data: got %h, expected 00000000", b3.rd_data); end
    tick();
    rst = 0;
    b0.rd_req = 0;
    for (int k = 0; k < 4; k++) begin
      exp_gnt = (k == 3);
      #1;
      checks++; if (b3.rd_gnt !== exp_gnt) begin errors++; $display("[TB] FAIL rstw_regnt%0d: got %b, expected %b", k, b3.rd_gnt, exp_gnt); end
      tick();
    end
    b3.rd_req = 0;
    checks++; if (b3.rd_data !== 32'hBEEF_0003) begin errors++; $display("[TB] FAIL rstw_post: got %h, expected beef0003", b3.rd_data); end
  endtask

  initial begin
    rst = 1;
    b0.rd_req = 0; b0.rd_be = 0; b0.rd_addr = 0; b0.wr_req = 0; b0.wr_be = 0; b0.wr_addr = 0; b0.wr_data = 0;
    b2.rd_req = 0; b2.rd_be = 0; b2.rd_addr = 0; b2.wr_req = 0; b2.wr_be = 0; b2.wr_addr = 0; b2.wr_data = 0;
    b3.rd_req = 0; b3.rd_be = 0; b3.rd_addr = 0; b3.wr_req = 0; b3.wr_be = 0; b3.wr_addr = 0; b3.wr_data = 0;
    bo.rd_req = 0; bo.rd_be = 0; bo.rd_addr = 0; bo.wr_req = 0; bo.wr_be = 0; bo.wr_addr = 0; bo.wr_data = 0;
    test_reset();
    test_back_to_back();
    test_byte_enable();
    test_same_cycle();
    test_wait_states();
    test_out_of_range();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
